// File: rtl/f32_pkg.sv
// Shared float32 definitions: field widths, exponent bias, operand class
// and the conversion FSM state encoding.
package f32_pkg;
   localparam int F32_W        = 32;
   localparam int F32_SIGN_W   = 1;
   localparam int F32_EXP_W    = 8;
   localparam int F32_MANT_W   = 23;
   localparam int F32_EXP_BIAS = 127;

   typedef enum logic [1:0] {
      CLS_ZERO,
      CLS_NORM,
      CLS_INF,
      CLS_NAN
   } f32_class_t;

   typedef enum logic [2:0] {
      IDLE,
      UNPACK,
      SHIFT,
      ROUND,
      DONE
   } f2i_state_t;
endpackage

// File: rtl/f2i_f32_if.sv
// Request/response bundle of the float32 to uint32 converter.
interface f2i_f32_if;
   import f32_pkg::*;

   logic             start;
   logic [F32_W-1:0] val;
   logic             busy;
   logic             rdy;
   logic [F32_W-1:0] result;
   logic             ovf;
   logic             inexact;

   modport master (
      output start, val,
      input  busy, rdy, result, ovf, inexact
   );

   modport slave (
      input  start, val,
      output busy, rdy, result, ovf, inexact
   );
endinterface

// File: rtl/f32_unpack.sv
// Combinational float32 field split and classification; the hidden bit
// is restored only for nonzero exponents.
module f32_unpack
   import f32_pkg::*;
(
   input  logic [F32_W-1:0]    val,
   output logic                sign,
   output logic [F32_EXP_W-1:0] expo,
   output logic [F32_MANT_W:0] mant,
   output f32_class_t          cls
);
   always_comb begin
      sign = val[F32_W-1];
      expo = val[F32_W-2 -: F32_EXP_W];
      mant = {(expo != '0), val[F32_MANT_W-1:0]};
      if (expo == '0) begin
         cls = CLS_ZERO;
      end else if (expo == '1) begin
         cls = (val[F32_MANT_W-1:0] != '0) ? CLS_NAN : CLS_INF;
      end else begin
         cls = CLS_NORM;
      end
   end
endmodule

// File: rtl/f2i_f32.sv
// Multi-cycle float32 to unsigned 32-bit integer converter, truncating,
// with saturation and overflow/inexact flags.
module f2i_f32
   import f32_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   f2i_f32_if.slave   bus
);
   f2i_state_t           state_q, state_d;
   logic [F32_W-1:0]     val_q, val_d;
   logic                 sign_q, sign_d;
   logic [F32_EXP_W-1:0] exp_q, exp_d;
   logic [F32_MANT_W:0]  mant_q, mant_d;
   f32_class_t           cls_q, cls_d;
   logic [55:0]          fix_q, fix_d;
   logic                 small_q, small_d;
   logic                 big_q, big_d;
   logic [F32_W-1:0]     result_q, result_d;
   logic                 ovf_q, ovf_d;
   logic                 inexact_q, inexact_d;
   logic                 busy_q, busy_d;
   logic                 rdy_q, rdy_d;

   logic                 u_sign;
   logic [F32_EXP_W-1:0] u_exp;
   logic [F32_MANT_W:0]  u_mant;
   f32_class_t           u_cls;

   f32_unpack u_unpack (
      .val  (val_q),
      .sign (u_sign),
      .expo (u_exp),
      .mant (u_mant),
      .cls  (u_cls)
   );

   always_comb begin
      state_d   = state_q;
      val_d     = val_q;
      sign_d    = sign_q;
      exp_d     = exp_q;
      mant_d    = mant_q;
      cls_d     = cls_q;
      fix_d     = fix_q;
      small_d   = small_q;
      big_d     = big_q;
      result_d  = result_q;
      ovf_d     = ovf_q;
      inexact_d = inexact_q;
      rdy_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               val_d   = bus.val;
               state_d = UNPACK;
            end
         end
         UNPACK: begin
            sign_d  = u_sign;
            exp_d   = u_exp;
            mant_d  = u_mant;
            cls_d   = u_cls;
            state_d = SHIFT;
         end
         SHIFT: begin
            // Binary point sits between bits 23 and 22; only shifts of 0..31
            // are consumed, the out-of-range cases are flagged separately.
            fix_d   = 56'(mant_q) << (exp_q - 8'(F32_EXP_BIAS));
            small_d = (exp_q < 8'(F32_EXP_BIAS));
            big_d   = (exp_q >= 8'(F32_EXP_BIAS + 32));
            state_d = ROUND;
         end
         ROUND: begin
            result_d  = '0;
            ovf_d     = 1'b0;
            inexact_d = 1'b0;
            case (cls_q)
               CLS_NAN: ovf_d = 1'b1;
               CLS_INF: begin
                  ovf_d = 1'b1;
                  if (!sign_q) result_d = '1;
               end
               CLS_ZERO: inexact_d = |mant_q;
               default: begin
                  if (small_q) begin
                     inexact_d = 1'b1;
                  end else if (sign_q) begin
                     ovf_d = 1'b1;
                  end else if (big_q || fix_q[55]) begin
                     result_d = '1;
                     ovf_d    = 1'b1;
                  end else begin
                     result_d  = fix_q[54:23];
                     inexact_d = |fix_q[22:0];
                  end
               end
            endcase
            rdy_d   = 1'b1;
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         val_q     <= '0;
         sign_q    <= 1'b0;
         exp_q     <= '0;
         mant_q    <= '0;
         cls_q     <= CLS_ZERO;
         fix_q     <= '0;
         small_q   <= 1'b0;
         big_q     <= 1'b0;
         result_q  <= '0;
         ovf_q     <= 1'b0;
         inexact_q <= 1'b0;
         busy_q    <= 1'b0;
         rdy_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         val_q     <= val_d;
         sign_q    <= sign_d;
         exp_q     <= exp_d;
         mant_q    <= mant_d;
         cls_q     <= cls_d;
         fix_q     <= fix_d;
         small_q   <= small_d;
         big_q     <= big_d;
         result_q  <= result_d;
         ovf_q     <= ovf_d;
         inexact_q <= inexact_d;
         busy_q    <= busy_d;
         rdy_q     <= rdy_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.rdy     = rdy_q;
   assign bus.result  = result_q;
   assign bus.ovf     = ovf_q;
   assign bus.inexact = inexact_q;
endmodule
